// File: rtl/sevga_pkg.sv
// Shared types and constants for the SE-VGA CPU read-back path.
package sevga_pkg;

  localparam int SEQ_W   = 3;
  localparam int VRAM_AW = 15;
  localparam int CPU_AW  = 23;

  localparam logic [SEQ_W-1:0] DEF_RD_SLOT  = 3'd5;
  localparam logic [8:0]       DEF_WIN_BASE = 9'h1F0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DECODE   = 3'd1,
    RD_HI    = 3'd2,
    RD_LO    = 3'd3,
    ACK      = 3'd4,
    WAIT_END = 3'd5
  } state_t;

  // Unstrobed byte lanes always read back as 8'hFF.
  function automatic logic [15:0] merge_lanes(input logic hi_en, input logic lo_en,
                                              input logic [15:0] d);
    return {hi_en ? d[15:8] : 8'hFF, lo_en ? d[7:0] : 8'hFF};
  endfunction

endpackage

// File: rtl/sevga_sync.sv
// N-stage reset-able synchronizer for asynchronous CPU strobes.
module sevga_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= {STAGES{RST_VAL}};
    end else begin
      sr[0] <= d;
      for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/vram_cpu_reader.sv
// Answers 68000 read cycles in the card window with VRAM bytes fetched in the CPU read slot.
// Optional single-word read cache enabled by defining SEVGA_RDCACHE_EN.
module vram_cpu_reader
  import sevga_pkg::*;
#(
  parameter logic [8:0]       WIN_BASE    = DEF_WIN_BASE,
  parameter logic [SEQ_W-1:0] RD_SLOT     = DEF_RD_SLOT,
  parameter int               SYNC_STAGES = 2
) (
  input  logic               pixClk,
  input  logic               reset,
  input  logic [SEQ_W-1:0]   seq,
  input  logic [CPU_AW-1:0]  cpuAddr,
  input  logic               ncpuAS,
  input  logic               ncpuUDS,
  input  logic               ncpuLDS,
  input  logic               cpuRnW,
  output logic [15:0]        cpuDataOut,
  output logic               cpuDataOE,
  output logic               ncpuDTACK,
  output logic [VRAM_AW-1:0] vramAddr,
  input  logic [7:0]         vramDataIn,
  output logic               nvramRdOE,
  input  logic               snpWE,
  input  logic [VRAM_AW-1:0] snpAddr,
  output logic [2:0]         dbg_state
);

  // Bus handshake: a cycle starts on synced AS low with RnW high; DTACK (with OE)
  // is held low from data-ready until synced AS returns high, then released.
  logic as_s, uds_s, lds_s, rnw_s;

  sevga_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_as  (.clk(pixClk), .rst(reset), .d(ncpuAS),  .q(as_s));
  sevga_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_uds (.clk(pixClk), .rst(reset), .d(ncpuUDS), .q(uds_s));
  sevga_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_lds (.clk(pixClk), .rst(reset), .d(ncpuLDS), .q(lds_s));
  sevga_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rnw (.clk(pixClk), .rst(reset), .d(cpuRnW),  .q(rnw_s));

  state_t      state, next;
  logic [13:0] word_q;
  logic [15:0] data_q;
  logic        uds_q, lds_q;
  logic        slot, win_hit, cache_hit;
  logic [15:0] hit_data;

  assign slot    = (seq == RD_SLOT);
  assign win_hit = (cpuAddr[22:14] == WIN_BASE) && (!uds_s || !lds_s) && !as_s;

`ifdef SEVGA_RDCACHE_EN
  logic        c_valid;
  logic [13:0] c_tag;
  logic [15:0] c_data;
  logic        fill, inval;

  // A snoop write to the entry being looked up or filled this cycle wins.
  assign cache_hit = c_valid && (c_tag == cpuAddr[13:0]) && !(snpWE && (snpAddr[14:1] == c_tag));
  assign hit_data  = merge_lanes(!uds_s, !lds_s, c_data);
  assign fill      = (state == RD_LO) && slot && !as_s && uds_q && lds_q;
  assign inval     = snpWE && (snpAddr[14:1] == (fill ? word_q : c_tag));

  always_ff @(posedge pixClk or posedge reset) begin
    if (reset) begin
      c_valid <= 1'b0;
      c_tag   <= '0;
      c_data  <= 16'hFFFF;
    end else begin
      if (fill) begin
        c_tag  <= word_q;
        c_data <= {data_q[15:8], vramDataIn};
      end
      if (inval)     c_valid <= 1'b0;
      else if (fill) c_valid <= 1'b1;
    end
  end

  logic unused_snp;
  assign unused_snp = snpAddr[0];
`else
  assign cache_hit = 1'b0;
  assign hit_data  = 16'hFFFF;

  logic unused_snp;
  assign unused_snp = ^{snpWE, snpAddr, uds_q};
`endif

  always_ff @(posedge pixClk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:     if (!as_s && rnw_s) next = DECODE;
      DECODE: begin
        if (!win_hit)      next = WAIT_END;
        else if (cache_hit) next = ACK;
        else if (!uds_s)    next = RD_HI;
        else                next = RD_LO;
      end
      RD_HI: begin
        if (as_s)      next = IDLE;
        else if (slot) next = lds_q ? RD_LO : ACK;
      end
      RD_LO: begin
        if (as_s)      next = IDLE;
        else if (slot) next = ACK;
      end
      ACK:      if (as_s) next = IDLE;
      WAIT_END: if (as_s) next = IDLE;
      default:  next = IDLE;
    endcase
  end

  always_ff @(posedge pixClk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      data_q <= 16'hFFFF;
      uds_q  <= 1'b0;
      lds_q  <= 1'b0;
    end else begin
      case (state)
        DECODE: begin
          word_q <= cpuAddr[13:0];
          uds_q  <= !uds_s;
          lds_q  <= !lds_s;
          data_q <= (win_hit && cache_hit) ? hit_data : 16'hFFFF;
        end
        RD_HI: if (!as_s && slot) data_q[15:8] <= vramDataIn;
        RD_LO: if (!as_s && slot) data_q[7:0]  <= vramDataIn;
        default: ;
      endcase
    end
  end

  // Outputs decode straight from state so reset clears them without a clock edge.
  assign cpuDataOut = data_q;
  assign cpuDataOE  = (state == ACK);
  assign ncpuDTACK  = !(state == ACK);
  assign vramAddr   = {word_q, (state == RD_LO)};
  assign nvramRdOE  = !(((state == RD_HI) || (state == RD_LO)) && slot);
  assign dbg_state  = state;

endmodule

// File: tb/tb_vram_cpu_reader.sv
// Self-checking bench for vram_cpu_reader: VRAM model, read-slot monitor and data scoreboard.
module tb_vram_cpu_reader;
  import sevga_pkg::*;

  logic        pixClk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  seq = 3'd0;
  logic [22:0] cpuAddr = '0;
  logic        ncpuAS = 1'b1, ncpuUDS = 1'b1, ncpuLDS = 1'b1, cpuRnW = 1'b1;
  logic [15:0] cpuDataOut;
  logic        cpuDataOE, ncpuDTACK, nvramRdOE;
  logic [14:0] vramAddr;
  logic [7:0]  vramDataIn;
  logic        snpWE = 1'b0;
  logic [14:0] snpAddr = '0;
  logic [2:0]  dbg_state;

  vram_cpu_reader dut (
    .pixClk(pixClk), .reset(reset), .seq(seq), .cpuAddr(cpuAddr),
    .ncpuAS(ncpuAS), .ncpuUDS(ncpuUDS), .ncpuLDS(ncpuLDS), .cpuRnW(cpuRnW),
    .cpuDataOut(cpuDataOut), .cpuDataOE(cpuDataOE), .ncpuDTACK(ncpuDTACK),
    .vramAddr(vramAddr), .vramDataIn(vramDataIn), .nvramRdOE(nvramRdOE),
    .snpWE(snpWE), .snpAddr(snpAddr), .dbg_state(dbg_state)
  );

  // clock / reset
  always #20 pixClk = ~pixClk;
  always @(posedge pixClk) seq <= seq + 3'd1;

  logic [7:0] vram_mem [0:32767];
  assign vramDataIn = vram_mem[vramAddr];

  int passed = 0;
  int total  = 0;
  logic [15:0] exp_q[$];
  logic [14:0] exp_addr_q[$];
  logic [14:0] mon_exp;
  logic        dtack_seen = 1'b0;

  logic        m_valid = 1'b0;
  logic [13:0] m_tag = '0;
  logic [15:0] m_data = '0;

  // Every VRAM read strobe must fall in slot 5 and match the next expected address.
  always @(negedge pixClk) begin
    if (!reset && nvramRdOE === 1'b0) begin
      total++;
      if (seq !== 3'd5) $display("FAIL rd_slot: strobe at seq %0d required 5", seq);
      else passed++;
      total++;
      if (exp_addr_q.size() == 0) begin
        $display("FAIL rd_unexpected: strobe at addr %h required none", vramAddr);
      end else begin
        mon_exp = exp_addr_q.pop_front();
        if (vramAddr !== mon_exp) $display("FAIL rd_addr: got %h required %h", vramAddr, mon_exp);
        else passed++;
      end
    end
    if (!reset && (ncpuDTACK === 1'b0 || cpuDataOE === 1'b1)) dtack_seen = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic start_cycle(input logic [8:0] base, input logic [13:0] w,
                             input logic uds, input logic lds, input logic rnw);
    @(negedge pixClk);
    cpuAddr = {base, w};
    cpuRnW  = rnw;
    ncpuUDS = !uds;
    ncpuLDS = !lds;
    ncpuAS  = 1'b0;
  endtask

  task automatic end_cycle();
    @(negedge pixClk);
    ncpuAS  = 1'b1;
    ncpuUDS = 1'b1;
    ncpuLDS = 1'b1;
    cpuRnW  = 1'b1;
  endtask

  task automatic model_read(input logic [13:0] w, input logic uds, input logic lds);
    logic [7:0] hi, lo;
`ifdef SEVGA_RDCACHE_EN
    if (m_valid && m_tag == w) begin
      exp_q.push_back({uds ? m_data[15:8] : 8'hFF, lds ? m_data[7:0] : 8'hFF});
      return;
    end
`endif
    hi = vram_mem[{w, 1'b0}];
    lo = vram_mem[{w, 1'b1}];
    if (uds) exp_addr_q.push_back({w, 1'b0});
    if (lds) exp_addr_q.push_back({w, 1'b1});
    exp_q.push_back({uds ? hi : 8'hFF, lds ? lo : 8'hFF});
    if (uds && lds) begin
      m_valid = 1'b1;
      m_tag   = w;
      m_data  = {hi, lo};
    end
  endtask

  task automatic do_read(input logic [13:0] w, input logic uds, input logic lds, output int lat);
    logic [15:0] exp;
    logic        held;
    int          rel;
    model_read(w, uds, lds);
    start_cycle(DEF_WIN_BASE, w, uds, lds, 1'b1);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge pixClk);
      if (ncpuDTACK === 1'b0) begin lat = i; break; end
    end
    exp = exp_q.pop_front();
    total++;
    if (lat == 0) begin
      $display("FAIL dtack_timeout: no DTACK in 40 clocks for word %h", w);
    end else begin
      passed++;
      total++;
      if (cpuDataOut !== exp) $display("FAIL read_data: got %h required %h", cpuDataOut, exp);
      else passed++;
      total++;
      if (cpuDataOE !== 1'b1) $display("FAIL read_oe: got %b required 1", cpuDataOE);
      else passed++;
    end
    held = 1'b1;
    repeat (3) begin
      @(negedge pixClk);
      if (ncpuDTACK !== 1'b0) held = 1'b0;
    end
    total++;
    if (!held) $display("FAIL dtack_hold: DTACK released while AS low, required held");
    else passed++;
    end_cycle();
    rel = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge pixClk);
      if (ncpuDTACK === 1'b1 && cpuDataOE === 1'b0) begin rel = i; break; end
    end
    total++;
    if (rel == 0) $display("FAIL dtack_release: DTACK %b OE %b required 1/0", ncpuDTACK, cpuDataOE);
    else passed++;
    repeat (2) @(negedge pixClk);
  endtask

  // tests
  task automatic test_reset();
    repeat (3) @(negedge pixClk);
    total++; if (ncpuDTACK !== 1'b1) $display("FAIL reset_dtack: got %b required 1", ncpuDTACK); else passed++;
    total++; if (cpuDataOE !== 1'b0) $display("FAIL reset_oe: got %b required 0", cpuDataOE); else passed++;
    total++; if (cpuDataOut !== 16'hFFFF) $display("FAIL reset_data: got %h required ffff", cpuDataOut); else passed++;
    total++; if (nvramRdOE !== 1'b1) $display("FAIL reset_rdoe: got %b required 1", nvramRdOE); else passed++;
    total++; if (vramAddr !== 15'h0) $display("FAIL reset_vaddr: got %h required 0000", vramAddr); else passed++;
    reset = 1'b0;
    repeat (2) @(negedge pixClk);
  endtask

  task automatic test_word_read();
    int lat;
    do_read(14'h0123, 1'b1, 1'b1, lat);
    total++;
    if (lat > 22) $display("FAIL word_latency: got %0d clocks required <= 22", lat);
    else passed++;
  endtask

  task automatic test_byte_read();
    int lat;
    do_read(14'h0123, 1'b0, 1'b1, lat);
    do_read(14'h0123, 1'b1, 1'b0, lat);
  endtask

  task automatic test_no_decode();
    dtack_seen = 1'b0;
    start_cycle(9'h000, 14'h0123, 1'b1, 1'b1, 1'b1);
    repeat (20) @(negedge pixClk);
    end_cycle();
    repeat (4) @(negedge pixClk);
    total++;
    if (dtack_seen) $display("FAIL miss_response: DTACK/OE seen required none"); else passed++;
    dtack_seen = 1'b0;
    start_cycle(DEF_WIN_BASE, 14'h0123, 1'b1, 1'b1, 1'b0);
    repeat (20) @(negedge pixClk);
    end_cycle();
    repeat (4) @(negedge pixClk);
    total++;
    if (dtack_seen) $display("FAIL write_response: DTACK/OE seen required none"); else passed++;
    total++;
    if (dbg_state !== 3'(IDLE)) $display("FAIL no_decode_idle: state %0d required %0d", dbg_state, IDLE);
    else passed++;
  endtask

  task automatic test_abort();
    logic seen;
    exp_addr_q.push_back({14'h0200, 1'b0});
    dtack_seen = 1'b0;
    start_cycle(DEF_WIN_BASE, 14'h0200, 1'b1, 1'b1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge pixClk);
      if (nvramRdOE === 1'b0) begin seen = 1'b1; break; end
    end
    ncpuAS = 1'b1; ncpuUDS = 1'b1; ncpuLDS = 1'b1;
    total++;
    if (!seen) $display("FAIL abort_hi_strobe: no high-byte strobe required one"); else passed++;
    repeat (12) @(negedge pixClk);
    total++;
    if (dtack_seen) $display("FAIL abort_dtack: DTACK/OE seen required none"); else passed++;
    total++;
    if (dbg_state !== 3'(IDLE)) $display("FAIL abort_idle: state %0d required %0d", dbg_state, IDLE);
    else passed++;
  endtask

  task automatic test_random_reads();
    int lat;
    logic [1:0] s;
    logic [13:0] w;
    for (int n = 0; n < 4; n++) begin
      w = 14'($urandom_range(14'h1000, 14'h1FFF));
      s = 2'($urandom_range(1, 3));
      do_read(w, s[1], s[0], lat);
    end
  endtask

`ifdef SEVGA_RDCACHE_EN
  task automatic test_cache();
    int lat;
    do_read(14'h0123, 1'b1, 1'b1, lat);
    do_read(14'h0123, 1'b1, 1'b1, lat);
    total++;
    if (lat > 4) $display("FAIL cache_latency: got %0d clocks required <= 4", lat); else passed++;
    @(negedge pixClk);
    snpAddr = 15'h0246;
    snpWE   = 1'b1;
    vram_mem[15'h0246] = 8'h5A;
    if (m_tag == 14'h0123) m_valid = 1'b0;
    @(negedge pixClk);
    snpWE = 1'b0;
    do_read(14'h0123, 1'b1, 1'b1, lat);
    total++;
    if (exp_addr_q.size() != 0) $display("FAIL cache_refetch: %0d strobes missing required 0", exp_addr_q.size());
    else passed++;
  endtask
`endif

  task automatic test_reset_mid_ack();
    logic [15:0] exp;
    logic        got;
    model_read(14'h0300, 1'b1, 1'b1);
    start_cycle(DEF_WIN_BASE, 14'h0300, 1'b1, 1'b1, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge pixClk);
      if (ncpuDTACK === 1'b0) begin got = 1'b1; break; end
    end
    exp = exp_q.pop_front();
    total++;
    if (!got) $display("FAIL mid_ack_dtack: no DTACK required low");
    else if (cpuDataOut !== exp) $display("FAIL mid_ack_data: got %h required %h", cpuDataOut, exp);
    else passed++;
    #5 reset = 1'b1;
    #1;
    total++; if (ncpuDTACK !== 1'b1) $display("FAIL mid_ack_rst_dtack: got %b required 1", ncpuDTACK); else passed++;
    total++; if (cpuDataOE !== 1'b0) $display("FAIL mid_ack_rst_oe: got %b required 0", cpuDataOE); else passed++;
    total++; if (cpuDataOut !== 16'hFFFF) $display("FAIL mid_ack_rst_data: got %h required ffff", cpuDataOut); else passed++;
    m_valid = 1'b0;
    ncpuAS = 1'b1; ncpuUDS = 1'b1; ncpuLDS = 1'b1;
    repeat (3) @(negedge pixClk);
    reset = 1'b0;
    repeat (2) @(negedge pixClk);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) vram_mem[i] = 8'($urandom_range(0, 255));
    vram_mem[15'h0246] = 8'hA5;
    vram_mem[15'h0247] = 8'h3C;
    test_reset();
    test_word_read();
    test_byte_read();
    test_no_decode();
    test_abort();
    test_random_reads();
`ifdef SEVGA_RDCACHE_EN
    test_cache();
`endif
    test_reset_mid_ack();
    total++;
    if (exp_addr_q.size() != 0) $display("FAIL strobe_queue: %0d strobes missing required 0", exp_addr_q.size());
    else passed++;
    total++;
    if (exp_q.size() != 0) $display("FAIL data_queue: %0d results left required 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vram_cpu_reader.md
Name: vram_cpu_reader

Overview:
- CPU read-back responder for the SE-VGA card: answers 68000 read cycles in a 32 KB card window with VRAM contents.
- Provides the opposite direction to the write snooper. The snooper captures CPU writes into VRAM; this block fetches VRAM bytes and returns them to the CPU with DTACK.
- VRAM accesses use only the CPU read slot of the 8-pixel sequence (seq = hCount[2:0]), so video fetch and snoop writes never collide.

Parameters:
- WIN_BASE, 9'h1F0: required value of cpuAddr[23:15] for a cycle to be decoded as a read-back.
- RD_SLOT, 3'd5: seq value during which this block owns the VRAM read path.
- SYNC_STAGES, 2: synchronizer depth for the asynchronous CPU strobes.

Ports:
- pixClk, input, 1: 25.175 MHz pixel clock, the only clock.
- reset, input, 1: asynchronous, active-high.
- seq, input, 3: pixel sequence counter, hCount[2:0].
- cpuAddr, input, 23: CPU address bus [23:1].
- ncpuAS, input, 1: CPU address strobe, async, active-low.
- ncpuUDS, input, 1: upper data strobe, active-low.
- ncpuLDS, input, 1: lower data strobe, active-low.
- cpuRnW, input, 1: 1 = read.
- cpuDataOut, output, 16: read data toward the CPU.
- cpuDataOE, output, 1: enables the CPU data bus drivers.
- ncpuDTACK, output, 1: data acknowledge, active-low (open-drain buffer outside this block).
- vramAddr, output, 15: VRAM byte address for the read.
- vramDataIn, input, 8: VRAM data bus.
- nvramRdOE, output, 1: VRAM read strobe, active-low, asserted only in RD_SLOT.
- snpWE, input, 1: snooper write strobe, active-high (used only with the optional feature).
- snpAddr, input, 15: snooper write byte address (used only with the optional feature).

Behaviour:
- Reset: state IDLE, cpuDataOut=16'hFFFF, cpuDataOE=0, ncpuDTACK=1, nvramRdOE=1, vramAddr=0.
- Reset asserted mid-cycle forces these values immediately, without waiting for a clock edge.
- Synchronization: ncpuAS, ncpuUDS, ncpuLDS and cpuRnW pass through SYNC_STAGES flops. cpuAddr is sampled raw in DECODE, where it is already stable.
- State machine:
  - IDLE -> DECODE when synced AS=0 and synced RnW=1.
  - DECODE: a hit requires cpuAddr[23:15]==WIN_BASE and at least one of UDS/LDS asserted. Latch word address cpuAddr[14:1]. Hit with UDS -> RD_HI; hit with LDS only -> RD_LO; miss -> WAIT_END with no response.
  - RD_HI: wait for seq==RD_SLOT. In that cycle vramAddr={word,1'b0} and nvramRdOE=0. At the next edge latch vramDataIn into cpuDataOut[15:8]. Then go to RD_LO if LDS is asserted, else ACK.
  - RD_LO: same as RD_HI with vramAddr={word,1'b1}, data into [7:0], then ACK. The low byte therefore lands 8 clocks after the high byte.
  - ACK: cpuDataOE=1 and ncpuDTACK=0, held until synced AS=1, then IDLE. Outputs deassert in the same edge IDLE is entered.
  - WAIT_END: do nothing until synced AS=1, then IDLE.
- Unstrobed byte lanes read 8'hFF.
- Latency from synced AS: best case 3 clocks for one byte; worst case 1+8+8+1=18 clocks for a word, under 0.75 us. 68000 wait states cover this.
- AS negated in RD_HI or RD_LO (aborted cycle): go to IDLE at the next edge. No DTACK, no OE; any in-progress nvramRdOE pulse completes its single cycle.
- Write cycles (RnW=0) are never decoded. Back-to-back reads require AS negation between them and always pass through IDLE.
- nvramRdOE is never low outside seq==RD_SLOT.

Optional Feature:
- Macro: SEVGA_RDCACHE_EN.
- With the macro: single-entry word cache (valid bit, 14-bit tag, 16-bit data).
  - DECODE hit with a matching valid tag goes straight to ACK using cached data.
  - A fresh two-byte read fills the cache.
  - snpWE=1 with snpAddr[14:1]==tag clears valid in the same cycle. An invalidate and a fill on the same edge resolve as invalidate.
  - Reset clears valid.
- Without the macro: every read accesses VRAM, and snpWE/snpAddr are ignored.

Decomposition:
- Package sevga_pkg holds:
  - the state enum (IDLE, DECODE, RD_HI, RD_LO, ACK, WAIT_END);
  - the SEQ_W=3, VRAM_AW=15 and CPU_AW=23 constants;
  - the default RD_SLOT.
- One sub-module, sevga_sync: a parameterized N-stage synchronizer with reset, instantiated for AS, UDS, LDS and RnW.

Test Plan:
- Reset mid-ACK: assert reset while ncpuDTACK=0 -> ncpuDTACK=1, cpuDataOE=0 and cpuDataOut=16'hFFFF with no clock edge.
- Word read, VRAM[0x0246]=8'hA5, VRAM[0x0247]=8'h3C, address {9'h1F0,14'h0123}, UDS=LDS=0 -> nvramRdOE pulses only at seq=5 with vramAddr 0x0246 then 0x0247 -> cpuDataOut=16'hA53C, DTACK low until AS high.
- Byte read, LDS only, same address -> single nvramRdOE pulse at 0x0247 -> cpuDataOut=16'hFF3C.
- Out-of-window read with cpuAddr[23:15]=9'h000, plus a write cycle inside the window -> no nvramRdOE, no DTACK, no OE for either.
- Abort: AS negated while in RD_LO -> IDLE next edge, ncpuDTACK stays 1, nvramRdOE never asserted off-slot.
- SEVGA_RDCACHE_EN: repeat the word read -> DTACK within 3 clocks, no nvramRdOE. Then pulse snpWE at 0x0246 and read again -> VRAM accessed and new data returned.
